// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM encoding and flag indices for alu_cmd_sequencer
package alu_seq_pkg;

   localparam logic [3:0] OP_NEG   = 4'h0;
   localparam logic [3:0] OP_INC   = 4'h1;
   localparam logic [3:0] OP_DEC   = 4'h2;
   localparam logic [3:0] OP_PASSA = 4'h3;
   localparam logic [3:0] OP_ADD   = 4'h4;
   localparam logic [3:0] OP_SUB   = 4'h5;
   localparam logic [3:0] OP_AND   = 4'h6;
   localparam logic [3:0] OP_OR    = 4'h7;
   localparam logic [3:0] OP_XOR   = 4'h8;
   localparam logic [3:0] OP_PASSB = 4'h9;
   localparam logic [3:0] OP_SHL   = 4'hA;
   localparam logic [3:0] OP_SHR   = 4'hB;
   localparam logic [3:0] OP_NAND  = 4'hC;
   localparam logic [3:0] OP_NOR   = 4'hD;
   localparam logic [3:0] OP_XNOR  = 4'hE;
   localparam logic [3:0] OP_NOP   = 4'hF;

   localparam int FLG_GT = 2;
   localparam int FLG_LT = 1;
   localparam int FLG_EQ = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic logic is_onehot3(input logic [2:0] f);
      return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
   endfunction

endpackage

// File: rtl/alu_seq_settle_timer.sv
// rtl/alu_seq_settle_timer.sv - loadable down-counter, done pulses while enabled at zero
module alu_seq_settle_timer #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_done
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_done = i_en && (r_count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response sequencer driving a combinational ALU
// Define ALU_SEQ_ACC_EN to let i_cmd_use_acc substitute the last captured result for operand a.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH         = 12,
   parameter int SEL_W         = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [SEL_W-1:0] i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_a,
   input  logic [WIDTH-1:0] i_cmd_b,
   input  logic             i_cmd_use_acc,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [SEL_W-1:0] o_alu_sel,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic [2:0]       i_alu_flags,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_result,
   output logic [2:0]       o_rsp_flags,
   output logic             o_rsp_err,
   output logic [CNT_W-1:0] o_op_count
);

   localparam int TW = $clog2(SETTLE_CYCLES + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [SEL_W-1:0] r_alu_sel;
   logic [WIDTH-1:0] r_rsp_result;
   logic [2:0]       r_rsp_flags;
   logic             r_rsp_err;
   logic [CNT_W-1:0] r_op_count;
   logic [WIDTH-1:0] w_a_src;
   logic             w_is_nop;
   logic             w_accept;
   logic             w_load;
   logic             w_settle;
   logic             w_done;
   logic             w_rsp_hs;

   assign w_is_nop = (i_cmd_op == SEL_W'(OP_NOP));
   assign w_accept = i_cmd_valid && o_cmd_ready;
   assign w_load   = w_accept && !w_is_nop;
   assign w_rsp_hs = o_rsp_valid && i_rsp_ready;

`ifdef ALU_SEQ_ACC_EN
   assign w_a_src = i_cmd_use_acc ? r_rsp_result : i_cmd_a;
`else
   logic w_unused_acc;
   assign w_unused_acc = i_cmd_use_acc;
   assign w_a_src      = i_cmd_a;
`endif

   alu_seq_settle_timer #(
      .W (TW)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_load_val (TW'(SETTLE_CYCLES - 1)),
      .i_en       (w_settle),
      .o_done     (w_done)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (i_cmd_valid) w_state_nxt = w_is_nop ? ST_RESP : ST_SETTLE;
         ST_SETTLE: if (w_done)      w_state_nxt = ST_RESP;
         ST_RESP:   if (i_rsp_ready) w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_cmd_ready = (r_state == ST_IDLE);
      o_rsp_valid = (r_state == ST_RESP);
      w_settle    = (r_state == ST_SETTLE);
   end

   // NOP leaves the ALU operands and the captured response untouched, so it replays the last result
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_sel    <= SEL_W'(OP_PASSA);
         r_rsp_result <= '0;
         r_rsp_flags  <= 3'b001;
         r_rsp_err    <= 1'b0;
         r_op_count   <= '0;
      end else begin
         if (w_load) begin
            r_alu_a   <= w_a_src;
            r_alu_b   <= i_cmd_b;
            r_alu_sel <= i_cmd_op;
         end
         if (w_done) begin
            r_rsp_result <= i_alu_result;
            r_rsp_flags  <= i_alu_flags;
            r_rsp_err    <= !is_onehot3(i_alu_flags);
         end
         if (w_rsp_hs) begin
            r_op_count <= r_op_count + CNT_W'(1);
         end
      end
   end

   assign o_alu_a      = r_alu_a;
   assign o_alu_b      = r_alu_b;
   assign o_alu_sel    = r_alu_sel;
   assign o_rsp_result = r_rsp_result;
   assign o_rsp_flags  = r_rsp_flags;
   assign o_rsp_err    = r_rsp_err;
   assign o_op_count   = r_op_count;

endmodule
